// File: rtl/serial_to_parallel_receiver.sv
// ---------------------------------------------------------------------------
// serial_to_parallel_receiver
//
// Rebuilds WIDTH-bit words from a 1-bit serial stream, one bit per qualified
// rising edge, and hands each finished word to a downstream consumer through
// a valid/ack handshake. A sticky overrun flag records that a finished word
// replaced one the consumer had not yet acknowledged.
//
// Parameters:
//   WIDTH       word length in bits (>= 2)
//   MSB_FIRST   1: first received bit ends up in dataOut[WIDTH-1]
//               0: first received bit ends up in dataOut[0]
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   enable       in   0 freezes the receive path (dataAck still honoured)
//   shiftEnable  in   dataIn carries a valid serial bit this cycle
//   dataIn       in   serial data bit
//   flush        in   synchronous discard of the partial frame
//   dataAck      in   consumer acknowledges the presented word
//   dataOut      out  last completed word
//   dataValid    out  dataOut holds an unacknowledged word
//   busy         out  a partial frame is in progress
//   overrun      out  sticky: a completed word overwrote an unacknowledged one
// ---------------------------------------------------------------------------
module serial_to_parallel_receiver #(
    parameter int unsigned WIDTH     = 6,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             shiftEnable,
    input  logic             dataIn,
    input  logic             flush,
    input  logic             dataAck,
    output logic [WIDTH-1:0] dataOut,
    output logic             dataValid,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned     CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q,     shreg_d;
    logic [CW-1:0]    bitCount_q,  bitCount_d;
    logic [WIDTH-1:0] dataOut_q,   dataOut_d;
    logic             dataValid_q, dataValid_d;
    logic             overrun_q,   overrun_d;

    logic [WIDTH-1:0] shifted;
    logic             acceptBit;

    // Shift register contents after taking in dataIn; the completed word is
    // captured from this value so the final bit is included in it.
    always_comb begin
        shifted = shreg_q;
        if (MSB_FIRST) begin
            shifted = {shreg_q[WIDTH-2:0], dataIn};
        end else begin
            shifted = {dataIn, shreg_q[WIDTH-1:1]};
        end
    end

    assign acceptBit = enable && shiftEnable && !flush;

    // Next-state logic. The ack clear is evaluated before the completion
    // path so that a word completing in the same cycle as an ack leaves
    // dataValid set without flagging an overrun.
    always_comb begin
        shreg_d     = shreg_q;
        bitCount_d  = bitCount_q;
        dataOut_d   = dataOut_q;
        dataValid_d = dataValid_q;
        overrun_d   = overrun_q;

        if (dataAck && dataValid_q) begin
            dataValid_d = 1'b0;
        end

        // Flush is part of the receive path, so a disabled block ignores it.
        if (enable && flush) begin
            shreg_d    = '0;
            bitCount_d = '0;
        end else if (acceptBit) begin
            shreg_d = shifted;
            if (bitCount_q == LAST_BIT) begin
                bitCount_d  = '0;
                dataOut_d   = shifted;
                dataValid_d = 1'b1;
                if (dataValid_q && !dataAck) begin
                    overrun_d = 1'b1;
                end
            end else begin
                bitCount_d = bitCount_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q     <= '0;
            bitCount_q  <= '0;
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bitCount_q  <= bitCount_d;
            dataOut_q   <= dataOut_d;
            dataValid_q <= dataValid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign dataOut   = dataOut_q;
    assign dataValid = dataValid_q;
    assign busy      = (bitCount_q != '0);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// ---------------------------------------------------------------------------
// tb_serial_to_parallel_receiver
//
// Drives an MSB-first and an LSB-first receiver from the same serial stream
// and checks the parallel words, handshake, busy and overrun behaviour
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_serial_to_parallel_receiver;

    localparam int W = 6;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         shiftEnable;
    logic         dataIn;
    logic         flush;
    logic         dataAck;

    logic [W-1:0] dataOutM;
    logic         dataValidM;
    logic         busyM;
    logic         overrunM;

    logic [W-1:0] dataOutL;
    logic         dataValidL;
    logic         busyL;
    logic         overrunL;

    int testsRun;
    int failCount;

    serial_to_parallel_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .shiftEnable (shiftEnable),
        .dataIn      (dataIn),
        .flush       (flush),
        .dataAck     (dataAck),
        .dataOut     (dataOutM),
        .dataValid   (dataValidM),
        .busy        (busyM),
        .overrun     (overrunM)
    );

    serial_to_parallel_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .shiftEnable (shiftEnable),
        .dataIn      (dataIn),
        .flush       (flush),
        .dataAck     (dataAck),
        .dataOut     (dataOutL),
        .dataValid   (dataValidL),
        .busy        (busyL),
        .overrun     (overrunL)
    );

    // 10 ns clock; inputs change and outputs are sampled 1 ns after each edge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one serial bit (optionally with an ack) across one rising edge
    task automatic applyStimulus(input logic bitVal, input logic ack);
        shiftEnable = 1'b1;
        dataIn      = bitVal;
        dataAck     = ack;
        @(posedge clk);
        #1;
        shiftEnable = 1'b0;
        dataIn      = 1'b0;
        dataAck     = 1'b0;
    endtask

    // One comparison: count it, and on mismatch count and report the failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Directed test sequence
    initial begin
        testsRun    = 0;
        failCount   = 0;
        reset       = 1'b1;
        enable      = 1'b1;
        shiftEnable = 1'b0;
        dataIn      = 1'b0;
        flush       = 1'b0;
        dataAck     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("reset dataOut",   32'(dataOutM),   32'd0);
        checkOutput("reset dataValid", 32'(dataValidM), 32'd0);
        checkOutput("reset busy",      32'(busyM),      32'd0);
        checkOutput("reset overrun",   32'(overrunM),   32'd0);

        // Word 1,0,0,1,0,0: MSB-first 36, LSB-first 9
        applyStimulus(1'b1, 1'b0);
        checkOutput("busy after bit1", 32'(busyM), 32'd1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("busy after bit5",    32'(busyM),      32'd1);
        checkOutput("valid before bit6",  32'(dataValidM), 32'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("msb word",           32'(dataOutM),   32'd36);
        checkOutput("msb valid",          32'(dataValidM), 32'd1);
        checkOutput("lsb word",           32'(dataOutL),   32'd9);
        checkOutput("busy after bit6",    32'(busyM),      32'd0);
        checkOutput("no overrun",         32'(overrunM),   32'd0);

        // Ack clears valid and leaves the word in place
        dataAck = 1'b1;
        @(posedge clk);
        #1;
        dataAck = 1'b0;
        checkOutput("ack clears valid", 32'(dataValidM), 32'd0);
        checkOutput("ack holds word",   32'(dataOutM),   32'd36);

        // Three bits, a four-cycle pause with noise on the inputs, then the rest
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            shiftEnable = ~shiftEnable;
            dataIn      = (i % 2 == 0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("busy during pause %0d", i), 32'(busyM), 32'd1);
        end
        shiftEnable = 1'b0;
        enable      = 1'b1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pause msb word", 32'(dataOutM),   32'd36);
        checkOutput("pause lsb word", 32'(dataOutL),   32'd9);
        checkOutput("pause valid",    32'(dataValidM), 32'd1);

        // Unacknowledged word replaced by 63 sets overrun
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("word held mid frame", 32'(dataOutM), 32'd36);
        applyStimulus(1'b1, 1'b0);
        checkOutput("overrun word",    32'(dataOutM),   32'd63);
        checkOutput("overrun valid",   32'(dataValidM), 32'd1);
        checkOutput("overrun flag",    32'(overrunM),   32'd1);

        // Overrun is sticky, so clear it with a reset before the ack variant
        reset = 1'b1;
        #2;
        reset = 1'b0;
        checkOutput("overrun cleared by reset", 32'(overrunM), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("ack+complete word",    32'(dataOutM),   32'd63);
        checkOutput("ack+complete valid",   32'(dataValidM), 32'd1);
        checkOutput("ack+complete overrun", 32'(overrunM),   32'd0);

        // Two bits, flush (with a bit offered, which must be dropped), new word
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        flush       = 1'b1;
        shiftEnable = 1'b1;
        dataIn      = 1'b1;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        shiftEnable = 1'b0;
        dataIn      = 1'b0;
        checkOutput("flush clears busy", 32'(busyM),    32'd0);
        checkOutput("flush keeps word",  32'(dataOutM), 32'd63);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("old word until done", 32'(dataOutM), 32'd63);
        applyStimulus(1'b1, 1'b0);
        checkOutput("flush msb word",   32'(dataOutM), 32'd21);
        checkOutput("flush lsb word",   32'(dataOutL), 32'd42);
        checkOutput("flush overrun",    32'(overrunM), 32'd1);

        // Asynchronous reset mid-frame, between edges
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("busy before async reset", 32'(busyM), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset dataOut",   32'(dataOutM),   32'd0);
        checkOutput("async reset dataValid", 32'(dataValidM), 32'd0);
        checkOutput("async reset busy",      32'(busyM),      32'd0);
        checkOutput("async reset overrun",   32'(overrunM),   32'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("post reset word",    32'(dataOutM),   32'd36);
        checkOutput("post reset valid",   32'(dataValidM), 32'd1);
        checkOutput("post reset overrun", 32'(overrunM),   32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
